pwm_deadtime: RTL

Dead-time insertion stage that sits directly downstream of the `pwm` generator. It consumes the single-ended `pwm_out` and produces a complementary high-side/low-side gate-drive pair. Both outputs are held low for a programmable number of clock cycles around every transition, so the two switches are never on together. A latched fault input forces both outputs off until software clears it.

---
 rtl/pwm_deadtime.sv | 129 ++++++++++++
 1 files changed

// File: rtl/pwm_deadtime.sv
// Dead-time insertion: turns a single-ended PWM into a complementary
// high-side/low-side gate-drive pair with a programmable blanking gap
// around every transition and a latched fault shutdown.
module pwm_deadtime #(
    parameter int unsigned DT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                pwm_in,
    input  logic [DT_WIDTH-1:0] dead_time,
    input  logic                fault,
    input  logic                clear_fault,
    output logic                hi_out,
    output logic                lo_out,
    output logic                fault_latched
);

    localparam logic [2:0] S_OFF    = 3'd0;
    localparam logic [2:0] S_DT_HI  = 3'd1;
    localparam logic [2:0] S_HI     = 3'd2;
    localparam logic [2:0] S_DT_LO  = 3'd3;
    localparam logic [2:0] S_LO     = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    logic [2:0]          state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic                pwm_q, pwm_d;
    logic                hi_q, hi_d;
    logic                lo_q, lo_d;
    logic                flt_q, flt_d;
    logic                dt_zero;
    logic                cnt_done;

    assign dt_zero  = (dead_time == '0);
    assign cnt_done = (cnt_q <= DT_WIDTH'(1));

    // Next-state, dead-time counter and output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pwm_d   = pwm_in;

        if (fault) begin
            state_d = S_FAULT;
        end else if (state_q == S_FAULT) begin
            if (clear_fault) begin
                state_d = S_OFF;
            end
        end else if (!enable) begin
            state_d = S_OFF;
        end else begin
            case (state_q)
                S_OFF: begin
                    cnt_d = dead_time;
                    if (pwm_q) begin
                        state_d = dt_zero ? S_HI : S_DT_HI;
                    end else begin
                        state_d = dt_zero ? S_LO : S_DT_LO;
                    end
                end
                S_HI: begin
                    if (!pwm_q) begin
                        cnt_d   = dead_time;
                        state_d = dt_zero ? S_LO : S_DT_LO;
                    end
                end
                S_LO: begin
                    if (pwm_q) begin
                        cnt_d   = dead_time;
                        state_d = dt_zero ? S_HI : S_DT_HI;
                    end
                end
                S_DT_HI: begin
                    // A reversal restarts the full dead time toward the other side
                    if (!pwm_q) begin
                        cnt_d   = dead_time;
                        state_d = S_DT_LO;
                    end else if (cnt_done) begin
                        state_d = S_HI;
                    end else begin
                        cnt_d = cnt_q - DT_WIDTH'(1);
                    end
                end
                S_DT_LO: begin
                    if (pwm_q) begin
                        cnt_d   = dead_time;
                        state_d = S_DT_HI;
                    end else if (cnt_done) begin
                        state_d = S_LO;
                    end else begin
                        cnt_d = cnt_q - DT_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = S_OFF;
                end
            endcase
        end

        hi_d  = (state_d == S_HI);
        lo_d  = (state_d == S_LO);
        flt_d = (state_d == S_FAULT);
    end

    // State, counter, input sample and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            pwm_q   <= 1'b0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
            flt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pwm_q   <= pwm_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            flt_q   <= flt_d;
        end
    end

    assign hi_out        = hi_q;
    assign lo_out        = lo_q;
    assign fault_latched = flt_q;

endmodule
